// File: rtl/sm_product_accumulator.sv
// Saturating dot-product accumulator for the PE datapath.
// Sums signed products until the last beat, then holds the result until it is consumed.
module sm_product_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [ACC_W-1:0] POS_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic signed [ACC_W-1:0] ext;
  logic [ACC_W:0]     sum;
  logic               pos_ovf, neg_ovf;
  logic               accept, consume;

  assign ext = ACC_W'($signed(in_data));
  assign sum = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
  // Sign bits of the wide sum disagree only on overflow.
  assign pos_ovf = ~sum[ACC_W] & sum[ACC_W-1];
  assign neg_ovf = sum[ACC_W] & ~sum[ACC_W-1];

  assign in_ready  = (state_q == ACCUM) & ~clear;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready & ~clear;

  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      clear, consume: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      accept: begin
        unique case (1'b1)
          pos_ovf: acc_d = POS_MAX;
          neg_ovf: acc_d = NEG_MIN;
          default: acc_d = sum[ACC_W-1:0];
        endcase
        ovf_d = ovf_q | pos_ovf | neg_ovf;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (in_last) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed bench for sm_product_accumulator.
// Expected results are queued by the stimulus and checked by a handshake monitor.
module tb_sm_product_accumulator;

  typedef struct {
    logic [31:0] data;
    logic [15:0] count;
    logic        ovf;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clear = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_ovf;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  sm_product_accumulator #(
    .DATA_W(32), .ACC_W(32), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares each consumed result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !clear) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(out_data), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_count", 64'(out_count), 64'(e.count));
          check("out_ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic expect_res(input logic [31:0] d,
                            input logic [15:0] c,
                            input logic o);
    exp_t e;
    e.data = d; e.count = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(sb.size()), 64'(0));
    #1;
  endtask

  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // +5, -3, +10 held for four cycles
    expect_res(32'd12, 16'd3, 1'b0);
    send(32'd5, 0);
    send(-32'sd3, 0);
    send(32'd10, 1);
    check("done_valid_edge", 64'(out_valid), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(out_data), 64'(12));
      check("hold_count", 64'(out_count), 64'(3));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1;
    drain();

    // Single term -1
    expect_res(32'hFFFF_FFFF, 16'd1, 1'b0);
    send(32'hFFFF_FFFF, 1);
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", 64'(in_ready), 64'(1));
    check("post_hs_data", 64'(out_data), 64'(0));
    check("post_hs_count", 64'(out_count), 64'(0));
    @(posedge clk); #1;

    // Zero product
    expect_res(32'd0, 16'd1, 1'b0);
    send(32'd0, 1);
    drain();

    // Positive saturation then recovery
    expect_res(32'h7FFF_FFEF, 16'd3, 1'b1);
    send(32'h7FFF_FFF0, 0);
    send(32'h0000_0020, 0);
    send(32'hFFFF_FFF0, 1);
    drain();
    expect_res(32'd2, 16'd1, 1'b0);
    send(32'd2, 1);
    drain();

    // Negative saturation
    expect_res(32'h8000_0000, 16'd2, 1'b1);
    send(32'h8000_0000, 0);
    send(32'hFFFF_FFFF, 1);
    drain();

    // Clear mid-accumulation with concurrent beat
    send(32'd7, 0);
    send(32'd8, 0);
    clear = 1; in_valid = 1; in_data = 32'd100;
    @(negedge clk);
    check("clear_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    clear = 0; in_valid = 0;
    check("clear_count", 64'(out_count), 64'(0));
    check("clear_data", 64'(out_data), 64'(0));
    expect_res(32'd1, 16'd1, 1'b0);
    send(32'd1, 1);
    drain();

    // Clear discards a handshake in DONE
    out_ready = 0;
    send(32'd9, 1);
    clear = 1; out_ready = 1;
    @(posedge clk); #1;
    clear = 0; out_ready = 0;
    check("clear_done_valid", 64'(out_valid), 64'(0));
    check("clear_done_data", 64'(out_data), 64'(0));

    // in_valid in DONE does not disturb result
    expect_res(32'd4, 16'd1, 1'b0);
    send(32'd4, 1);
    in_valid = 1; in_data = 32'h55; in_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_ignore_data", 64'(out_data), 64'(4));
      check("done_ignore_cnt", 64'(out_count), 64'(1));
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    out_ready = 1;
    drain();

    // Asynchronous reset mid-accumulation
    out_ready = 0;
    send(32'd3, 0);
    send(32'd6, 0);
    #2;
    rst_n = 0;
    #1;
    check("arst_data", 64'(out_data), 64'(0));
    check("arst_count", 64'(out_count), 64'(0));
    check("arst_ovf", 64'(out_ovf), 64'(0));
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    expect_res(32'd11, 16'd1, 1'b0);
    send(32'd11, 1);
    drain();

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
